// File: rtl/inst_prefetch_queue_if.sv
// Fetch-side bundle between ID/IF-ID and the prefetch queue, plus the instruction memory port.
// slave is the queue's view; master is the environment's view (ID stage, IF/ID and memory).
interface inst_prefetch_queue_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pop;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport slave (
        input  redirect, redirect_pc, pop, imem_ack, imem_rdata,
        output inst_valid, inst, pc4, imem_req, imem_addr
    );

    modport master (
        output redirect, redirect_pc, pop, imem_ack, imem_rdata,
        input  inst_valid, inst, pc4, imem_req, imem_addr
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential req/ack fetches buffered into a DEPTH-entry FIFO, flushed on redirect.
// Latency: ack to head-visible is one cycle; backpressure: a request issues only when a slot is reserved for it.
module inst_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_prefetch_queue_if.slave  bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d, count_nxt;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       imem_addr_q, imem_addr_d;
    logic              imem_req_q;
    logic [31:0]       inst_mem_q [DEPTH];
    logic [31:0]       pc4_mem_q  [DEPTH];

    logic        push_w, pop_w, space_w, empty_w;
    logic [31:0] addr_inc_w;

    assign empty_w    = (count_q == '0);
    assign addr_inc_w = imem_addr_q + 32'd4;
    // Redirect squashes both the returning word and any same-cycle consume.
    assign push_w     = (state_q == REQ) && bus.imem_ack && !bus.redirect;
    assign pop_w      = bus.pop && !empty_w && !bus.redirect;
    assign count_nxt  = count_q + CNT_W'(push_w) - CNT_W'(pop_w);
    assign space_w    = (count_nxt < DEPTH_C);

    always_comb begin
        state_d     = state_q;
        count_d     = count_nxt;
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop_w);
        wr_ptr_d    = wr_ptr_q + PTR_W'(push_w);
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;

        if (bus.redirect) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = bus.redirect_pc;
            // An in-flight request cannot be cancelled, so its data must be swallowed later.
            if ((state_q != IDLE) && !bus.imem_ack) begin
                state_d = DROP;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (space_w) begin
                        state_d     = REQ;
                        imem_addr_d = fetch_pc_q;
                    end
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        fetch_pc_d = addr_inc_w;
                        if (space_w) begin
                            imem_addr_d = addr_inc_w;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= '0;
            imem_req_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
            imem_req_q  <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pc4_mem_q[wr_ptr_q]  <= addr_inc_w;
        end
    end

    assign bus.inst_valid = !empty_w;
    assign bus.inst       = empty_w ? 32'h0 : inst_mem_q[rd_ptr_q];
    assign bus.pc4        = empty_w ? 32'h0 : pc4_mem_q[rd_ptr_q];
    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue (DEPTH=4, RESET_PC=0); memory returns addr|A000_0000.
module tb_inst_prefetch_queue;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    inst_prefetch_queue_if bus ();

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.imem_rdata = bus.imem_addr | 32'hA000_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic pop, input logic redir, input logic [31:0] rpc);
        bus.imem_ack    = ack;
        bus.pop         = pop;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
    endtask

    task automatic check_empty(input string tag);
        chk({tag, ".valid"}, 32'(bus.inst_valid), 32'd0);
        chk({tag, ".inst"},  bus.inst,            32'h0);
        chk({tag, ".pc4"},   bus.pc4,             32'h0);
    endtask

    task automatic check_head(input string tag, input logic [31:0] i, input logic [31:0] p);
        chk({tag, ".valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, ".inst"},  bus.inst,            i);
        chk({tag, ".pc4"},   bus.pc4,             p);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(bus.imem_req), 32'(req));
        if (req) chk({tag, ".addr"}, bus.imem_addr, addr);
    endtask

    // Leaves rst_n asserted; caller releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset state
        do_reset();
        check_empty("rst");
        chk("rst.req",  32'(bus.imem_req), 32'd0);
        chk("rst.addr", bus.imem_addr,     32'h0);

        // Streaming with zero-wait ack and pop whenever valid
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_req("str.first", 1'b1, 32'h0);
        check_empty("str.first");
        for (int i = 0; i < 6; i++) begin
            bus.pop = bus.inst_valid;
            step();
            check_req($sformatf("str%0d", i), 1'b1, 32'(4 * (i + 1)));
            check_head($sformatf("str%0d", i), 32'hA000_0000 | 32'(4 * i), 32'(4 * i + 4));
        end

        // Fill to full, then a single pop reopens fetch
        do_reset();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        step();
        step();
        check_req("fill.c", 1'b1, 32'hC);
        step();
        check_req("fill.full", 1'b0, 32'h0);
        check_head("fill.full", 32'hA000_0000, 32'h4);
        step();
        check_req("fill.stray", 1'b0, 32'h0);
        check_head("fill.stray", 32'hA000_0000, 32'h4);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_req("fill.pop", 1'b1, 32'h10);
        check_head("fill.pop", 32'hA000_0004, 32'h8);

        // Redirect while a request for 0x8 is outstanding
        do_reset();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_req("rdo.hold", 1'b1, 32'h8);
        check_head("rdo.hold", 32'hA000_0000, 32'h4);
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        step();
        check_empty("rdo.flush");
        check_req("rdo.flush", 1'b1, 32'h8);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_req("rdo.wait", 1'b1, 32'h8);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_empty("rdo.drop");
        check_req("rdo.drop", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_req("rdo.new", 1'b1, 32'h100);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_head("rdo.first", 32'hA000_0100, 32'h104);

        // Redirect with same-cycle ack and pop
        do_reset();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        check_head("rap.pre", 32'hA000_0000, 32'h4);
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        step();
        check_empty("rap.flush");
        check_req("rap.flush", 1'b0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_req("rap.new", 1'b1, 32'h200);
        check_empty("rap.new");
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_head("rap.first", 32'hA000_0200, 32'h204);

        // Pop on empty and stray ack while IDLE
        drive(1'b1, 1'b1, 1'b1, 32'h300);
        step();
        check_empty("stray.idle");
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        step();
        check_empty("stray.after");
        check_req("stray.after", 1'b1, 32'h300);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        check_empty("stray.popempty");
        check_req("stray.popempty", 1'b1, 32'h300);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_head("stray.first", 32'hA000_0300, 32'h304);

        // Reset with 3 entries queued and a request outstanding
        do_reset();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        step();
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check_req("mrst.pre", 1'b1, 32'hC);
        check_head("mrst.pre", 32'hA000_0000, 32'h4);
        rst_n = 1'b0;
        step();
        check_empty("mrst.rst");
        chk("mrst.rst.req",  32'(bus.imem_req), 32'd0);
        chk("mrst.rst.addr", bus.imem_addr,     32'h0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check_empty("mrst.stale");
        check_req("mrst.stale", 1'b1, 32'h0);
        step();
        check_head("mrst.first", 32'hA000_0000, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_prefetch_queue.md
Name: inst_prefetch_queue

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and in place of the raw instruction-memory read in the fetch stage.
- Issues sequential word fetches to a multi-cycle instruction memory over a req/ack handshake and buffers the returned words in a small FIFO.
- Presents the head instruction and its PC+4 to IF/ID.
- Flushes and restarts fetch on a branch/jump/jr redirect from ID.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- redirect  in  1  taken branch/jump/jr from ID; flush and refetch.
- redirect_pc  in  32  new fetch address (BeqAdr/JmpAdr/JrAdr); word aligned.
- pop  in  1  IF/ID consumes the head entry (IF_ID_Write qualified).
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction; 32'h0 (NOP) when empty.
- pc4  out  32  head entry address + 4; 32'h0 when empty.
- imem_req  out  1  fetch request; registered.
- imem_addr  out  32  fetch address; registered, stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  fetched word.

Behaviour:
- Reset (rst_n=0 at an edge; the clk edge alone has effect): count=0, rd/wr pointers=0, fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0. inst_valid=0, inst=0, pc4=0. Applies mid-transaction: any outstanding ack after reset release is ignored while in IDLE.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, data will be kept.
  - DROP: request outstanding, data will be discarded.
  - imem_req=1 exactly in REQ and DROP.
- Space rule: space = (count_next < DEPTH), where count_next is count after this cycle's push/pop. A request is outstanding only when a slot is reserved for it.
- IDLE transitions:
  - If space: next state REQ, imem_addr<=fetch_pc.
  - Otherwise stay IDLE.
- REQ transitions:
  - On imem_ack: push {imem_rdata, imem_addr+4}; fetch_pc<=imem_addr+4.
  - If space remains after the push: stay REQ with imem_addr<=imem_addr+4. This gives back-to-back streaming at 1 word/cycle with zero-wait ack.
  - Else go to IDLE.
  - No ack: hold req and addr.
- DROP transitions:
  - On imem_ack: discard rdata; go to IDLE.
  - Requests are never aborted.
- Redirect (highest priority):
  - count<=0 and pointers reset; fetch_pc<=redirect_pc.
  - A same-cycle pop is ignored.
  - If in REQ or DROP and no ack this cycle: go to DROP.
  - If an ack arrives the same cycle: discard the word and go to IDLE.
  - From IDLE: go to IDLE; the request to redirect_pc issues the next cycle.
  - Redirect while in DROP updates fetch_pc again and stays in DROP.
- pop with count=0 is ignored. Push and pop in the same cycle leave count unchanged.
- imem_ack while in IDLE is ignored.
- Output timing: outputs are driven combinationally from the head register. A word pushed at edge N is visible as inst_valid=1 after edge N, so latency from ack to IF/ID availability is one cycle.
- Invariant: count never exceeds DEPTH. Addresses increment by 4 and wrap modulo 2^32.

Test Plan:
- Stream (DEPTH=4):
  - Stimulus: reset, RESET_PC=0, imem_ack=1 every cycle, pop=1 whenever valid, rdata=addr|32'hA000_0000.
  - Required: imem_req rises 1 cycle after reset release with imem_addr=0. Then addrs 0,4,8,... one per cycle. inst/pc4 sequence A000_0000/4, A000_0004/8, ...
- Fill to full:
  - Stimulus: pop=0, ack every cycle.
  - Required: exactly addrs 0x0,0x4,0x8,0xC accepted; imem_req=0 afterwards; inst_valid=1 with inst=A000_0000.
  - Then one pop: head becomes A000_0004 and imem_addr=0x10 issues the next cycle.
- Redirect with outstanding request:
  - Stimulus: ack withheld while addr=0x8, redirect=1 with redirect_pc=0x100.
  - Required: inst_valid=0 the next cycle; the later ack for 0x8 is dropped; next request addr=0x100; first valid inst has pc4=0x104.
- Redirect with same-cycle ack and pop:
  - Required: queue empty afterwards; neither the acked word nor the popped entry appears later; next request is redirect_pc.
- Pop on empty and stray ack:
  - Stimulus: pop=1 with count=0; imem_ack=1 in IDLE.
  - Required: no state change; inst=0, pc4=0, inst_valid=0.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one edge with 3 entries queued and a request outstanding.
  - Required: all outputs zero; next request addr=RESET_PC; the stale ack is ignored.
